// File: rtl/fsm_ctrl_pkg.sv
// Shared definitions for the additive-sequence control FSM:
// state encoding and ALU opcodes driven onto the datapath.
package fsm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SEED0 = 3'd2,
    SEED1 = 3'd3,
    RUN   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h05;

endpackage : fsm_ctrl_pkg

// File: rtl/reg_onehot_dec.sv
// Register-index to one-hot write-enable decoder. Indices beyond the
// register file decode to all zeros so no write can land out of range.
module reg_onehot_dec #(
  parameter int NREGS = 16,
  parameter int RW    = 4
) (
  input  logic [RW-1:0]    idx,
  input  logic             en,
  output logic [NREGS-1:0] onehot
);

  // One-hot decode of idx, gated by en.
  always_comb begin
    // NOTE: default every output first so no path through the block infers a latch.
    onehot = '0;
    if (en && (int'(idx) < NREGS)) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule : reg_onehot_dec

// File: rtl/fsm_seq_ctrl.sv
// Control FSM that drives the register file / ALU so that R0..R[L] hold an
// additive sequence R[k] = R[k-1] + R[k-2] seeded by seed0/seed1.
// Optional feature macro: FSM_FLAGS_EN (flag enables during RUN, abort on carry).
module fsm_seq_ctrl
  import fsm_ctrl_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int RW    = 4,
  parameter int DATAW = 16,
  parameter int OPW   = 8,
  parameter int FLAGW = 5
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             start,
  input  logic [RW-1:0]    lastIdx,
  input  logic [DATAW-1:0] seed0,
  input  logic [DATAW-1:0] seed1,
  input  logic             stepEn,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [NREGS-1:0] enableRegs,
  output logic [NREGS-1:0] resRegs,
  output logic [OPW-1:0]   opCode,
  output logic [FLAGW-1:0] enableFlags,
  output logic [RW-1:0]    muxRsrc,
  output logic [RW-1:0]    muxRdest,
  output logic             muxRI,
  output logic [DATAW-1:0] immVal
);

  state_t           state;
  logic [RW-1:0]    k;
  logic [RW-1:0]    l_q;
  logic [RW-1:0]    l_clamp;
  logic [DATAW-1:0] seed0_q;
  logic [DATAW-1:0] seed1_q;
  logic             ovf_q;
  logic             carry_hit;
  logic             dec_en;
  logic [RW-1:0]    dec_idx;

`ifdef FSM_FLAGS_EN
  assign carry_hit = carryIn;
`else
  // Carry has no effect without the flag feature; the sink keeps it visibly unused.
  logic unused_carry;
  assign unused_carry = carryIn;
  assign carry_hit    = 1'b0;
`endif

  // Clamp the requested last index into [1, NREGS-1]; below 2 there is no RUN phase.
  always_comb begin
    l_clamp = lastIdx;
    if (int'(lastIdx) > NREGS - 1) begin
      l_clamp = RW'(NREGS - 1);
    end
    if (l_clamp < RW'(2)) begin
      l_clamp = RW'(1);
    end
  end

  // Sequencer: state, step counter and the operands latched at start.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      state   <= IDLE;
      k       <= '0;
      l_q     <= RW'(1);
      seed0_q <= '0;
      seed1_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (start) begin
            l_q     <= l_clamp;
            seed0_q <= seed0;
            seed1_q <= seed1;
            ovf_q   <= 1'b0;
            state   <= CLEAR;
          end
        end
        CLEAR: if (stepEn) state <= SEED0;
        SEED0: if (stepEn) state <= SEED1;
        SEED1: begin
          if (stepEn) begin
            k     <= RW'(2);
            state <= (l_q == RW'(1)) ? DONE : RUN;
          end
        end
        RUN: begin
          if (stepEn) begin
            if (carry_hit) begin
              ovf_q <= 1'b1;
              state <= DONE;
            end else if (k == l_q) begin
              state <= DONE;
            end else begin
              k <= k + RW'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath controls decoded from the registered state; stalls gate only writes.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    dec_en      = 1'b0;
    dec_idx     = '0;
    resRegs     = '0;
    opCode      = OPW'(OP_NOP);
    enableFlags = '0;
    muxRsrc     = '0;
    muxRdest    = '0;
    muxRI       = 1'b0;
    immVal      = '0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (stepEn) resRegs = '1;
      end
      SEED0: begin
        busy    = 1'b1;
        opCode  = OPW'(OP_ADD);
        muxRI   = 1'b1;
        immVal  = seed0_q;
        dec_idx = '0;
        dec_en  = stepEn;
      end
      SEED1: begin
        busy    = 1'b1;
        opCode  = OPW'(OP_ADD);
        muxRI   = 1'b1;
        immVal  = seed1_q;
        dec_idx = RW'(1);
        dec_en  = stepEn;
      end
      RUN: begin
        busy     = 1'b1;
        opCode   = OPW'(OP_ADD);
        muxRsrc  = k - RW'(1);
        muxRdest = k - RW'(2);
        dec_idx  = k;
        dec_en   = stepEn;
`ifdef FSM_FLAGS_EN
        if (stepEn) enableFlags = '1;
`endif
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign ovf = ovf_q;

  reg_onehot_dec #(
    .NREGS (NREGS),
    .RW    (RW)
  ) u_dec (
    .idx    (dec_idx),
    .en     (dec_en),
    .onehot (enableRegs)
  );

endmodule : fsm_seq_ctrl

// File: tb/tb_fsm_seq_ctrl.sv
// Self-checking bench for fsm_seq_ctrl: a behavioural register file driven by
// the DUT controls, checked against the sequence computed directly from seeds.
module tb_fsm_seq_ctrl;

  localparam int NREGS = 16;
  localparam int RW    = 4;
  localparam int DATAW = 16;
  localparam int OPW   = 8;
  localparam int FLAGW = 5;

  logic             clk;
  logic             rs;
  logic             start;
  logic [RW-1:0]    lastIdx;
  logic [DATAW-1:0] seed0;
  logic [DATAW-1:0] seed1;
  logic             stepEn;
  logic             carryIn;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [NREGS-1:0] enableRegs;
  logic [NREGS-1:0] resRegs;
  logic [OPW-1:0]   opCode;
  logic [FLAGW-1:0] enableFlags;
  logic [RW-1:0]    muxRsrc;
  logic [RW-1:0]    muxRdest;
  logic             muxRI;
  logic [DATAW-1:0] immVal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATAW-1:0] regs[NREGS];
  bit               written[NREGS];

  fsm_seq_ctrl #(
    .NREGS (NREGS), .RW (RW), .DATAW (DATAW), .OPW (OPW), .FLAGW (FLAGW)
  ) dut (
    .clk (clk), .rs (rs), .start (start), .lastIdx (lastIdx),
    .seed0 (seed0), .seed1 (seed1), .stepEn (stepEn), .carryIn (carryIn),
    .busy (busy), .done (done), .ovf (ovf),
    .enableRegs (enableRegs), .resRegs (resRegs), .opCode (opCode),
    .enableFlags (enableFlags), .muxRsrc (muxRsrc), .muxRdest (muxRdest),
    .muxRI (muxRI), .immVal (immVal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_en"}, 32'(enableRegs), 32'd0);
    check({tag, "_res"}, 32'(resRegs), 32'd0);
    check({tag, "_op"}, 32'(opCode), 32'h00);
    check({tag, "_flags"}, 32'(enableFlags), 32'd0);
    check({tag, "_sel"}, {muxRsrc, muxRdest, 7'(muxRI)}, 32'd0);
    check({tag, "_imm"}, 32'(immVal), 32'd0);
  endtask

  // One run from start to the idle cycle after done.
  // stall_c0 > 0 forces stepEn low for cycles stall_c0..stall_c0+2.
  // abort_c > 0 pulses reset in that cycle and ends the run there.
  // exp_done_c >= 0 also checks the absolute cycle of the done pulse.
  task automatic do_run(input int lidx, input logic [DATAW-1:0] s0, input logic [DATAW-1:0] s1,
                        input int stall_pct, input int stall_c0, input int carry_k,
                        input int abort_c, input int exp_done_c);
    int leff, need, last, n_active;
    bit exp_ovf;
    logic [DATAW-1:0] refv[NREGS];
    logic [NREGS-1:0] exp_en, exp_res;
    logic [FLAGW-1:0] exp_flags;
    logic [DATAW-1:0] wval;

    leff = (lidx > NREGS - 1) ? NREGS - 1 : lidx;
    if (leff < 2) leff = 1;
    need    = leff + 2;
    exp_ovf = 1'b0;
`ifdef FSM_FLAGS_EN
    if (carry_k >= 2 && carry_k <= leff) begin
      need    = carry_k + 2;
      exp_ovf = 1'b1;
    end
`endif
    last = need - 2;

    refv[0] = s0;
    refv[1] = s1;
    for (int i = 2; i < NREGS; i++) refv[i] = refv[i-1] + refv[i-2];
    for (int i = 0; i < NREGS; i++) written[i] = 1'b0;

    @(negedge clk);
    start   = 1'b1;
    lastIdx = RW'(lidx);
    seed0   = s0;
    seed1   = s1;
    stepEn  = 1'b1;
    carryIn = 1'b0;
    #1;
    check("start_busy", 32'(busy), 32'd0);

    n_active = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start   = 1'b0;
      lastIdx = RW'($urandom);
      seed0   = DATAW'($urandom);
      seed1   = DATAW'($urandom);
      if (c == abort_c) begin
        rs = 1'b1;
        #1;
        check_idle("abort");
        check("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rs = 1'b0;
        return;
      end
      stepEn = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
      if (stall_c0 > 0 && c >= stall_c0 && c < stall_c0 + 3) stepEn = 1'b0;
`ifdef FSM_FLAGS_EN
      carryIn = (carry_k > 0) && (n_active == carry_k + 1);
`else
      carryIn = 1'($urandom);
`endif
      if (n_active == need) start = 1'b1;
      #1;

      if (n_active == need) begin
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_ovf", 32'(ovf), 32'(exp_ovf));
        check("done_en", 32'(enableRegs), 32'd0);
        if (exp_done_c >= 0) check("done_cycle", c, exp_done_c);
        for (int i = 0; i < NREGS; i++) begin
          if (i <= last) check($sformatf("R%0d", i), 32'(regs[i]), 32'(refv[i]));
          else           check($sformatf("R%0d_untouched", i), 32'(written[i]), 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        check_idle("after_done");
        check("ovf_held", 32'(ovf), 32'(exp_ovf));
        return;
      end

      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);

      // Active step n: 0 clears, 1 and 2 load seeds, n>=3 writes term n-1.
      exp_en    = '0;
      exp_res   = '0;
      exp_flags = '0;
      if (stepEn) begin
        if (n_active == 0)      exp_res = '1;
        else if (n_active == 1) exp_en  = NREGS'(1);
        else if (n_active == 2) exp_en  = NREGS'(2);
        else begin
          exp_en = NREGS'(1) << (n_active - 1);
`ifdef FSM_FLAGS_EN
          exp_flags = '1;
`endif
        end
      end
      check("step_en", 32'(enableRegs), 32'(exp_en));
      check("step_res", 32'(resRegs), 32'(exp_res));
      check("step_flags", 32'(enableFlags), 32'(exp_flags));
      if (enableRegs != '0) check("step_op", 32'(opCode), 32'h05);

      // Behavioural register file / ALU reacting to the control outputs.
      wval = muxRI ? immVal : regs[muxRsrc] + regs[muxRdest];
      for (int i = 0; i < NREGS; i++) begin
        if (resRegs[i]) regs[i] = '0;
        if (enableRegs[i]) begin
          regs[i]    = wval;
          written[i] = 1'b1;
        end
      end
      if (stepEn) n_active++;
    end
    check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rs      = 1'b1;
    start   = 1'b0;
    lastIdx = '0;
    seed0   = '0;
    seed1   = '0;
    stepEn  = 1'b1;
    carryIn = 1'b0;
    for (int i = 0; i < NREGS; i++) regs[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    check("reset_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rs = 1'b0;

    // Fibonacci to R15.
    do_run(15, 16'd0, 16'd1, 0, 0, 0, 0, 18);
    check("fib15", 32'(regs[15]), 32'd610);
    // Lucas to R5.
    do_run(5, 16'd2, 16'd1, 0, 0, 0, 0, 8);
    check("lucas5", 32'(regs[5]), 32'd11);
    // Shortest run: seeds only.
    do_run(1, 16'd7, 16'd9, 0, 0, 0, 0, 4);
    do_run(0, 16'd3, 16'd4, 0, 0, 0, 0, 4);
    // Three stalled cycles in the middle of RUN.
    do_run(9, 16'd0, 16'd1, 0, 6, 0, 0, 15);
    check("fib9", 32'(regs[9]), 32'd34);
    // Reset while writing R6, then a clean short run.
    do_run(9, 16'd0, 16'd1, 0, 0, 0, 8, -1);
    do_run(3, 16'd0, 16'd1, 0, 0, 0, 0, 6);
    check("fib3", 32'(regs[3]), 32'd2);
`ifdef FSM_FLAGS_EN
    // Carry on the R4 step aborts the run with ovf.
    do_run(9, 16'd0, 16'd1, 0, 0, 4, 0, 7);
    check("carry_r4", 32'(regs[4]), 32'd3);
`endif

    // Randomized runs with random stalls, seeds and term counts.
    for (int r = 0; r < 25; r++) begin
      do_run(int'($urandom_range(NREGS - 1)), DATAW'($urandom), DATAW'($urandom),
             25, 0, int'($urandom_range(NREGS - 1)), 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fsm_seq_ctrl
